rx_frame_controller: RTL and testbench
======================================

// Module: rx_frame_controller
// PURPOSE
//  Sequences the 5-bit bit-period counter to receive asynchronous serial frames in the demo receiver.
//  Holds the counter cleared while idle and releases it on a start edge.
//  Samples rx_in at mid-bit using the counter value and assembles an LSB-first data word.
//  Sits between the receive pin and the display/decode logic.
// PARAMETERS
//  DATA_BITS  8   data bits per frame (1..16)
//  SAMPLE_PT  15  counter value at which the line is sampled (0..30)
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-low reset
//  rx_in         in   1          raw serial line, idle high, asynchronous to clk
//  cnt_count     in   5          bit-period counter value
//  cnt_complete  in   1          counter terminal flag, high while cnt_count==31
//  cnt_reset     out  1          active-low clear to counter; 0 holds counter at 0
//  data_out      out  DATA_BITS  last good frame, held until next good frame
//  data_valid    out  1          one-cycle pulse, new data_out
//  frame_err     out  1          one-cycle pulse, stop bit sampled low
//  busy          out  1          high in any state other than IDLE
// BEHAVIOUR
//  Counter contract: while cnt_reset=1, count increments each clk and wraps 31->0; 32 clk per bit.
//  Reset (reset=0, async): state=IDLE, cnt_reset=0, data_out=0, data_valid=0, frame_err=0,
//    busy=0, shift reg=0, bit_idx=0, sync flops=1, armed=0. Reset mid-frame discards the frame.
//  rx_in passes through 2-flop synchronizer (rx_s); all decisions use rx_s.
//  armed: set when rx_s==1 in IDLE; cleared on leaving IDLE. A start requires armed=1.
//  IDLE: cnt_reset=0. If armed and rx_s==0 -> START; cnt_reset goes 1 (registered) next cycle.
//  START: at cnt_count==SAMPLE_PT: rx_s==1 -> false start, IDLE (cnt_reset=0, no pulse).
//    At cnt_complete -> DATA, bit_idx=0.
//  DATA: at cnt_count==SAMPLE_PT shift rx_s in LSB-first (shift right, new bit at MSB).
//    At cnt_complete: bit_idx==DATA_BITS-1 -> STOP, else bit_idx+1.
//  STOP: at cnt_count==SAMPLE_PT: rx_s==1 -> data_out<=shift reg, data_valid=1 next cycle;
//    rx_s==0 -> frame_err=1 next cycle, data_out unchanged. Either way -> IDLE, cnt_reset=0.
//  Pulses are registered and last exactly one clk. data_valid and frame_err never both high.
//  Latency: start edge on rx_in to data_valid = 2 sync + 1 + (DATA_BITS+1)*32 + SAMPLE_PT + 1 clk.
//  Line stuck low after stop error: armed=0, no new START until rx_s seen high for >=1 clk.
//  Back-to-back frames: start bit immediately after stop sample is accepted (armed set by stop level).
//  cnt_complete without matching cnt_count==31 is not checked; controller uses values as given.
//  busy=0 only in IDLE; cnt_reset=~(state==IDLE) registered.
// STRUCTURE
//  Shared include rx_ctrl_defs.vh: state encodings IDLE/START/DATA/STOP (2-bit),
//    CNT_W=5, BIT_PERIOD=32.
//  Sub-module rx_sync: 2-flop synchronizer, reset value 1, output rx_s.
//  Top: FSM, bit_idx counter ($clog2(DATA_BITS) bits), shift reg, output registers.
// TESTING (bench instantiates controller with the bit-period counter; clk period 10 ns)
//  Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1), 32 clk/bit -> one data_valid, data_out=8'hA5, frame_err=0.
//  rx_in low for 5 clk then high -> returns IDLE at sample point, cnt_reset=0, no pulses, busy 0.
//  Frame 0x3C with stop bit low -> frame_err one pulse, data_valid=0, data_out keeps prior 8'hA5.
//  reset=0 during DATA bit 4 -> same cycle busy=0, cnt_reset=0, data_out=0; next frame 0x5A received OK.
//  Back-to-back 0x00 then 0xFF, no idle gap -> two data_valid pulses 320 clk apart, values 00 then FF.
//  rx_in held low 2000 clk -> exactly one frame_err, then no START until rx_in returns high.

Source files
------------

// File: rtl/rx_frame_controller_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// bit-period counter geometry.
package rx_frame_controller_pkg;

  localparam int CNT_W      = 5;
  localparam int BIT_PERIOD = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_frame_controller_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level
// so a reset never looks like a start edge.
module rx_frame_controller_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s
);

  logic r_meta;
  logic r_rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= rx_in;
      r_rx_s <= r_meta;
    end
  end

  assign rx_s = r_rx_s;

endmodule

// File: rtl/rx_frame_controller.sv
// Receive-frame sequencer: gates the external bit-period counter, samples the
// synchronized line at mid-bit and assembles an LSB-first data word.
module rx_frame_controller
  import rx_frame_controller_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SAMPLE_PT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic [4:0]           cnt_count,
  input  logic                 cnt_complete,
  output logic                 cnt_reset,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int                 IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]   SAMPLE_CNT = CNT_W'(SAMPLE_PT % BIT_PERIOD);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DATA_BITS - 1);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic                 w_rx_s;
  logic                 w_at_sample;
  logic                 w_shift_en;
  logic                 w_valid_set;
  logic                 w_err_set;
  logic                 w_idx_clr;
  logic                 w_idx_inc;
  logic                 r_armed;
  logic                 r_cnt_reset;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data_out;

  rx_frame_controller_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_in (rx_in),
    .rx_s  (w_rx_s)
  );

  assign w_at_sample = (cnt_count == SAMPLE_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_valid_set = 1'b0;
    w_err_set   = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (w_at_sample && w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else if (cnt_complete) begin
          w_state_nxt = ST_DATA;
          w_idx_clr   = 1'b1;
        end
      end
      ST_DATA: begin
        w_shift_en = w_at_sample;
        if (cnt_complete) begin
          if (r_bit_idx == LAST_IDX) w_state_nxt = ST_STOP;
          else                       w_idx_inc   = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_at_sample) begin
          w_state_nxt = ST_IDLE;
          w_valid_set = w_rx_s;
          w_err_set   = !w_rx_s;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // New bit enters at the MSB so the first received bit ends up in bit 0.
  always_comb begin
    w_shift_nxt                = r_shift >> 1;
    w_shift_nxt[DATA_BITS-1]   = w_rx_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      r_cnt_reset  <= 1'b0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // Only a high line seen while idle may arm the next start detection.
      r_armed      <= (r_state == ST_IDLE) ? (r_armed | w_rx_s) : 1'b0;
      r_cnt_reset  <= (w_state_nxt != ST_IDLE);
      r_data_valid <= w_valid_set;
      r_frame_err  <= w_err_set;
      if (w_idx_clr)      r_bit_idx <= '0;
      else if (w_idx_inc) r_bit_idx <= r_bit_idx + 1'b1;
      if (w_shift_en)  r_shift    <= w_shift_nxt;
      if (w_valid_set) r_data_out <= r_shift;
    end
  end

  assign cnt_reset  = r_cnt_reset;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: drives serial frames through the controller and
// a bit-period counter, comparing against a frame-level model of the receiver.
module tb_rx_frame_controller;

  localparam int DATA_BITS = 8;
  localparam int SAMPLE_PT = 15;
  localparam int LATENCY   = 2 + 1 + (DATA_BITS + 1) * 32 + SAMPLE_PT + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic [4:0] cnt_count = '0;
  logic       cnt_complete;
  logic       cnt_reset;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_valid  = 0;
  int         n_err    = 0;
  int         last_valid_cyc = 0;
  int         valid_cyc_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  logic [7:0] model_data = '0;
  int         start_cyc  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!cnt_reset) cnt_count <= '0;
    else            cnt_count <= cnt_count + 5'd1;
  end
  assign cnt_complete = (cnt_count == 5'd31);

  rx_frame_controller #(
    .DATA_BITS (DATA_BITS),
    .SAMPLE_PT (SAMPLE_PT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .cnt_count    (cnt_count),
    .cnt_complete (cnt_complete),
    .cnt_reset    (cnt_reset),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: counts events, records valid timing, enforces pulse shape.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin
        n_valid        <= n_valid + 1;
        last_valid_cyc <= cyc;
        valid_cyc_q.push_back(cyc);
        check_eq("vld_err_excl", 32'(frame_err), 32'd0);
        check_eq("vld_one_clk", 32'(prev_valid), 32'd0);
      end
      if (frame_err) begin
        n_err <= n_err + 1;
        check_eq("err_one_clk", 32'(prev_err), 32'd0);
      end
      prev_valid <= data_valid;
      prev_err   <= frame_err;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    rx_in     = 1'b0;
    start_cyc = cyc;
    wait_clk(32);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_in = d[i];
      wait_clk(32);
    end
    rx_in = stop_lvl;
    wait_clk(32);
    rx_in = 1'b1;
  endtask

  // Frame-level model: a good stop bit delivers the word, a bad one only flags.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_ok,
                           input int gap);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(d, stop_ok);
    if (stop_ok) model_data = d;
    check_eq({tag, "_vld"}, 32'(n_valid - v0), stop_ok ? 32'd1 : 32'd0);
    check_eq({tag, "_err"}, 32'(n_err - e0), stop_ok ? 32'd0 : 32'd1);
    check_eq({tag, "_data"}, 32'(data_out), 32'(model_data));
    wait_clk(gap);
  endtask

  initial begin
    int         v0;
    int         e0;
    int         q0;
    logic [7:0] d;
    logic       ok;
    logic       prev_ok;
    int         gap;

    reset = 1'b0;
    rx_in = 1'b1;
    wait_clk(3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt_reset", 32'(cnt_reset), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    wait_clk(5);

    run_frame("a5", 8'hA5, 1'b1, 20);
    check_eq("a5_latency", 32'(last_valid_cyc - start_cyc), 32'(LATENCY));

    v0 = n_valid;
    e0 = n_err;
    rx_in = 1'b0;
    wait_clk(5);
    rx_in = 1'b1;
    wait_clk(5);
    check_eq("false_start_busy_mid", 32'(busy), 32'd1);
    wait_clk(30);
    check_eq("false_start_busy", 32'(busy), 32'd0);
    check_eq("false_start_cnt_reset", 32'(cnt_reset), 32'd0);
    check_eq("false_start_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'd0);

    run_frame("3c_badstop", 8'h3C, 1'b0, 20);

    d = 8'hC3;
    rx_in = 1'b0;
    wait_clk(32);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      wait_clk(32);
    end
    rx_in = d[4];
    wait_clk(10);
    check_eq("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    rx_in = 1'b1;
    #1;
    model_data = '0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_cnt_reset", 32'(cnt_reset), 32'd0);
    check_eq("midrst_data_out", 32'(data_out), 32'd0);
    wait_clk(2);
    reset = 1'b1;
    wait_clk(10);
    run_frame("5a", 8'h5A, 1'b1, 20);

    q0 = valid_cyc_q.size();
    run_frame("b2b_00", 8'h00, 1'b1, 0);
    run_frame("b2b_ff", 8'hFF, 1'b1, 20);
    check_eq("b2b_pulses", 32'(valid_cyc_q.size() - q0), 32'd2);
    if (valid_cyc_q.size() >= q0 + 2)
      check_eq("b2b_spacing", 32'(valid_cyc_q[q0+1] - valid_cyc_q[q0]), 32'd320);

    v0 = n_valid;
    e0 = n_err;
    rx_in = 1'b0;
    wait_clk(1000);
    check_eq("stuck_busy_mid", 32'(busy), 32'd0);
    wait_clk(1000);
    check_eq("stuck_err", 32'(n_err - e0), 32'd1);
    check_eq("stuck_vld", 32'(n_valid - v0), 32'd0);
    check_eq("stuck_busy_end", 32'(busy), 32'd0);
    check_eq("stuck_data", 32'(data_out), 32'(model_data));
    rx_in = 1'b1;
    wait_clk(40);
    check_eq("stuck_release_busy", 32'(busy), 32'd0);
    check_eq("stuck_release_err", 32'(n_err - e0), 32'd1);

    // After a low stop bit the line must be seen high before the next start.
    prev_ok = 1'b1;
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = prev_ok ? int'($urandom_range(0, 40)) : int'($urandom_range(2, 40));
      if (!ok && gap < 2) gap = 2;
      run_frame("rnd", d, ok, gap);
      prev_ok = ok;
    end

    wait_clk(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
